// File: rtl/sram_param_model_pkg.sv
// Shared constants and helpers for the parametrised SRAM model.
package sram_param_model_pkg;

    localparam int RD_LAT_MAX = 3;   // deepest supported read pipeline
    localparam int BYTE_W     = 8;   // width of one byte lane
    localparam int WR_CNT_W   = 16;  // width of the committed-write counter

    typedef logic [WR_CNT_W-1:0] wr_cnt_t;

    // Bus cycle classification derived from the strobes.
    typedef enum logic [1:0] {
        CYC_IDLE,
        CYC_READ,
        CYC_WRITE
    } cyc_kind_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic wr_cnt_t sat_inc(input wr_cnt_t v);
        return (v == '1) ? v : v + wr_cnt_t'(1);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line: LAT stages of {valid, data, lane mask}.
module sram_rd_pipe
    import sram_param_model_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n_i,
    input  logic                     in_valid_i,
    input  logic [DATA_W-1:0]        in_data_i,
    input  logic [DATA_W/BYTE_W-1:0] in_mask_i,
    output logic                     out_valid_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [DATA_W/BYTE_W-1:0] out_mask_o
);

    localparam int LANES = DATA_W / BYTE_W;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [LANES-1:0]  mask;
    } rd_entry_t;

    rd_entry_t in_entry;
    rd_entry_t stage_q [LAT];

    assign in_entry = {in_valid_i, in_data_i, in_mask_i};

    // Shift one entry per clock; reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            // NOTE: only the valid bits are reset; data/mask are don't-care while invalid.
            for (int i = 0; i < LAT; i++) begin
                stage_q[i].valid <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
            stage_q[0] <= in_entry;
            for (int i = 1; i < LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_valid_o = stage_q[LAT-1].valid;
    assign out_data_o  = stage_q[LAT-1].data;
    assign out_mask_o  = stage_q[LAT-1].mask;

endmodule

// File: rtl/sram_param_model.sv
// Parametrised synchronous SRAM with byte enables, optional read pipeline,
// sticky out-of-range / bus-conflict flags and a saturating write counter.
module sram_param_model
    import sram_param_model_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 19,
    parameter int DEPTH     = 64,
    parameter int RD_LAT    = 0,
    parameter int INIT_ZERO = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        SRAM_ADDR,
    inout  wire  [DATA_W-1:0]        SRAM_DQ,
    input  logic [DATA_W/BYTE_W-1:0] SRAM_BE_N,
    input  logic                     SRAM_CE_N,
    input  logic                     SRAM_OE_N,
    input  logic                     SRAM_WE_N,
    output logic                     oor_err,
    output logic                     bus_conflict,
    output logic [WR_CNT_W-1:0]      wr_cnt
);

    localparam int LANES = DATA_W / BYTE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Out-of-range latencies are clamped to the supported window.
    localparam int LAT   = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : ((RD_LAT < 0) ? 0 : RD_LAT);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    cyc_kind_t         cyc_kind;
    logic              in_range;
    logic              wr_commit;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] lane_bits;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;
    logic [LANES-1:0]  pipe_mask;
    logic [DATA_W-1:0] pipe_bits;

    logic              oor_err_q, oor_err_d;
    logic              bus_conflict_q, bus_conflict_d;
    wr_cnt_t           wr_cnt_q, wr_cnt_d;

    // Classify the current bus cycle; write wins over read when both strobes are low.
    always_comb begin
        // NOTE: default first so every path assigns cyc_kind and no latch is inferred.
        cyc_kind = CYC_IDLE;
        if (!SRAM_CE_N) begin
            if (!SRAM_WE_N) begin
                cyc_kind = CYC_WRITE;
            end else if (!SRAM_OE_N) begin
                cyc_kind = CYC_READ;
            end
        end
    end

    assign in_range  = ({1'b0, SRAM_ADDR} < DEPTH_EXT);
    assign idx       = SRAM_ADDR[IDX_W-1:0];
    assign wr_commit = (cyc_kind == CYC_WRITE) && in_range && !(&SRAM_BE_N);
    assign rd_word   = in_range ? mem_q[idx] : '0;

    // Expand per-lane enables into per-bit masks for the write and read paths.
    always_comb begin
        lane_bits = '0;
        pipe_bits = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_bits[i*BYTE_W +: BYTE_W] = {BYTE_W{~SRAM_BE_N[i]}};
            pipe_bits[i*BYTE_W +: BYTE_W] = {BYTE_W{pipe_mask[i]}};
        end
    end

    // Storage array: byte-lane merge on write, optional clear on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: contents survive reset unless INIT_ZERO asks for a full clear.
            if (INIT_ZERO != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end
        end else if (wr_commit) begin
            mem_q[idx] <= (mem_q[idx] & ~lane_bits) | (SRAM_DQ & lane_bits);
        end
    end

    // Read path: combinational for zero latency, otherwise a delay line.
    if (LAT == 0) begin : g_rd_comb
        assign pipe_valid = (cyc_kind == CYC_READ);
        assign pipe_data  = rd_word;
        assign pipe_mask  = ~SRAM_BE_N;
    end else begin : g_rd_pipe
        sram_rd_pipe #(
            .DATA_W (DATA_W),
            .LAT    (LAT)
        ) u_rd_pipe (
            .clk         (clk),
            .rst_n_i     (rst),
            .in_valid_i  (cyc_kind == CYC_READ),
            .in_data_i   (rd_word),
            .in_mask_i   (~SRAM_BE_N),
            .out_valid_o (pipe_valid),
            .out_data_o  (pipe_data),
            .out_mask_o  (pipe_mask)
        );
    end

    // A matured read yields the bus to any write strobe and its data is lost.
    assign SRAM_DQ = (pipe_valid && SRAM_WE_N) ? (pipe_data & pipe_bits) : {DATA_W{1'bz}};

    // Next-state for the sticky flags and the saturating write counter.
    always_comb begin
        oor_err_d      = oor_err_q | ((cyc_kind != CYC_IDLE) && !in_range);
        bus_conflict_d = bus_conflict_q | (pipe_valid && !SRAM_WE_N);
        wr_cnt_d       = wr_commit ? sat_inc(wr_cnt_q) : wr_cnt_q;
    end

    // Status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            oor_err_q      <= 1'b0;
            bus_conflict_q <= 1'b0;
            wr_cnt_q       <= '0;
        end else begin
            oor_err_q      <= oor_err_d;
            bus_conflict_q <= bus_conflict_d;
            wr_cnt_q       <= wr_cnt_d;
        end
    end

    assign oor_err      = oor_err_q;
    assign bus_conflict = bus_conflict_q;
    assign wr_cnt       = wr_cnt_q;

endmodule

// File: tb/tb_sram_param_model.sv
// Bench for sram_param_model: three instances (RD_LAT 0/1/2) share one
// stimulus stream; each data bus has pull-ups so an undriven bus reads all-ones.
module tb_sram_param_model;

    localparam int DW = 16;
    localparam int AW = 19;
    localparam logic [15:0] Z_READ = 16'hFFFF;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [1:0]    be_n;
        logic [15:0]   wdata;
        logic [15:0]   exp_dq;
        logic [15:0]   exp_cnt;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [1:0]    be_n;
    logic          ce_n, oe_n, we_n;
    logic          tb_drv;
    logic [15:0]   tb_dq;

    wire  [15:0]   dq0, dq1, dq2;
    logic          oor0, oor1, oor2;
    logic          bc0, bc1, bc2;
    logic [15:0]   cnt0, cnt1, cnt2;

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t vecs [11];
    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];

    always #5 clk = ~clk;

    assign dq0 = tb_drv ? tb_dq : 16'hzzzz;
    assign dq1 = tb_drv ? tb_dq : 16'hzzzz;
    assign dq2 = tb_drv ? tb_dq : 16'hzzzz;

    for (genvar i = 0; i < DW; i++) begin : g_pull
        pullup (dq0[i]);
        pullup (dq1[i]);
        pullup (dq2[i]);
    end

    sram_param_model #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64), .RD_LAT(0), .INIT_ZERO(0)) u_lat0 (
        .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq0), .SRAM_BE_N(be_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
        .oor_err(oor0), .bus_conflict(bc0), .wr_cnt(cnt0));

    sram_param_model #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64), .RD_LAT(1), .INIT_ZERO(0)) u_lat1 (
        .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq1), .SRAM_BE_N(be_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
        .oor_err(oor1), .bus_conflict(bc1), .wr_cnt(cnt1));

    sram_param_model #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(64), .RD_LAT(2), .INIT_ZERO(0)) u_lat2 (
        .clk(clk), .rst(rst), .SRAM_ADDR(addr), .SRAM_DQ(dq2), .SRAM_BE_N(be_n),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
        .oor_err(oor2), .bus_conflict(bc2), .wr_cnt(cnt2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [AW-1:0] a,
                         input logic [1:0] b, input logic [15:0] d);
        ce_n   = !(w || r);
        we_n   = !w;
        oe_n   = !r;
        addr   = a;
        be_n   = b;
        tb_drv = w;
        tb_dq  = d;
    endtask

    task automatic go_idle();
        drive(1'b0, 1'b0, '0, 2'b11, 16'h0000);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        go_idle();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic sb_push(input int k, input int due, input logic [15:0] data);
        exp_t e;
        e.due  = due;
        e.data = data;
        case (k)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    // Compare one bus against the scoreboard entry due this cycle, or Z if none.
    task automatic sb_check(input int k, input int cyc);
        logic [15:0] act;
        logic [15:0] expv;
        exp_t        e;
        expv = Z_READ;
        case (k)
            0: begin
                act = dq0;
                if (sb0.size() > 0 && sb0[0].due == cyc) begin e = sb0.pop_front(); expv = e.data; end
            end
            1: begin
                act = dq1;
                if (sb1.size() > 0 && sb1[0].due == cyc) begin e = sb1.pop_front(); expv = e.data; end
            end
            default: begin
                act = dq2;
                if (sb2.size() > 0 && sb2[0].due == cyc) begin e = sb2.pop_front(); expv = e.data; end
            end
        endcase
        check($sformatf("burst c%0d lat%0d dq", cyc, k), {16'h0, act}, {16'h0, expv});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] wa [5];
        logic [15:0]   wd [5];
        int            burst_addr [6];
        logic [15:0]   e;

        vecs[0]  = '{1'b1, 19'd5, 2'b00, 16'hA5C3, 16'h0000, 16'd0};
        vecs[1]  = '{1'b0, 19'd5, 2'b00, 16'h0000, 16'hA5C3, 16'd1};
        vecs[2]  = '{1'b1, 19'd7, 2'b00, 16'h1234, 16'h0000, 16'd1};
        vecs[3]  = '{1'b1, 19'd7, 2'b10, 16'hFFFF, 16'h0000, 16'd2};
        vecs[4]  = '{1'b0, 19'd7, 2'b00, 16'h0000, 16'h12FF, 16'd3};
        vecs[5]  = '{1'b0, 19'd7, 2'b01, 16'h0000, 16'h1200, 16'd3};
        vecs[6]  = '{1'b1, 19'd8, 2'b11, 16'hBEEF, 16'h0000, 16'd3};
        vecs[7]  = '{1'b1, 19'd8, 2'b00, 16'h0F0F, 16'h0000, 16'd3};
        vecs[8]  = '{1'b1, 19'd8, 2'b11, 16'hBEEF, 16'h0000, 16'd4};
        vecs[9]  = '{1'b0, 19'd8, 2'b00, 16'h0000, 16'h0F0F, 16'd4};
        vecs[10] = '{1'b0, 19'd5, 2'b10, 16'h0000, 16'h00C3, 16'd4};

        wa = '{19'd1, 19'd2, 19'd3, 19'd4, 19'd0};
        wd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0A0A};
        burst_addr = '{1, 2, 3, -1, -1, -1};

        // Power-on reset: two reset edges, then check the cleared state.
        rst = 1'b0;
        go_idle();
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("reset oor0", {31'h0, oor0}, 32'h0);
        check("reset oor2", {31'h0, oor2}, 32'h0);
        check("reset bc1", {31'h0, bc1}, 32'h0);
        check("reset bc2", {31'h0, bc2}, 32'h0);
        check("reset cnt0", {16'h0, cnt0}, 32'h0);
        check("reset cnt1", {16'h0, cnt1}, 32'h0);
        check("reset dq0", {16'h0, dq0}, {16'h0, Z_READ});
        check("reset dq1", {16'h0, dq1}, {16'h0, Z_READ});
        check("reset dq2", {16'h0, dq2}, {16'h0, Z_READ});
        next_cycle();

        // Table-driven writes/reads on the zero-latency instance.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].wr, !vecs[i].wr, vecs[i].addr, vecs[i].be_n, vecs[i].wdata);
            @(negedge clk);
            if (!vecs[i].wr) begin
                check($sformatf("vec%0d dq", i), {16'h0, dq0}, {16'h0, vecs[i].exp_dq});
            end
            check($sformatf("vec%0d wr_cnt", i), {16'h0, cnt0}, {16'h0, vecs[i].exp_cnt});
            next_cycle();
        end

        // Preload addresses 0..4, then a three-read burst scored on all latencies.
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, wa[i], 2'b00, wd[i]);
            next_cycle();
        end
        go_idle();
        @(negedge clk);
        check("preload wr_cnt", {16'h0, cnt0}, 32'd5);
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            if (burst_addr[c] >= 0) begin
                drive(1'b0, 1'b1, AW'(burst_addr[c]), 2'b00, 16'h0000);
                e = 16'(16'h1111 * burst_addr[c]);
                sb_push(0, c, e);
                sb_push(1, c + 1, e);
                sb_push(2, c + 2, e);
            end else begin
                go_idle();
            end
            @(negedge clk);
            sb_check(0, c);
            sb_check(1, c);
            sb_check(2, c);
            next_cycle();
        end
        check("scoreboard drained", sb0.size() + sb1.size() + sb2.size(), 32'd0);

        // Write colliding with a matured latency-1 read.
        drive(1'b0, 1'b1, 19'd4, 2'b00, 16'h0000);
        @(negedge clk);
        check("conflict pre read dq0", {16'h0, dq0}, 32'h4444);
        next_cycle();
        drive(1'b1, 1'b0, 19'd9, 2'b00, 16'h9A9A);
        @(negedge clk);
        check("conflict dq1 undriven", {16'h0, dq1}, 32'h9A9A);
        next_cycle();
        go_idle();
        @(negedge clk);
        check("conflict bc1 set", {31'h0, bc1}, 32'h1);
        check("conflict bc2 clear", {31'h0, bc2}, 32'h0);
        check("conflict bc0 clear", {31'h0, bc0}, 32'h0);
        check("conflict lat2 dq", {16'h0, dq2}, 32'h4444);
        next_cycle();
        drive(1'b0, 1'b1, 19'd9, 2'b00, 16'h0000);
        @(negedge clk);
        check("conflict write landed", {16'h0, dq0}, 32'h9A9A);
        next_cycle();
        go_idle();
        @(negedge clk);
        check("conflict lat1 readback", {16'h0, dq1}, 32'h9A9A);
        check("conflict bc1 sticky", {31'h0, bc1}, 32'h1);
        check("conflict wr_cnt", {16'h0, cnt0}, 32'd6);
        next_cycle();
        @(negedge clk);
        check("conflict lat2 readback", {16'h0, dq2}, 32'h9A9A);
        next_cycle();

        // Out-of-range accesses.
        drive(1'b1, 1'b0, 19'd64, 2'b00, 16'h5555);
        next_cycle();
        drive(1'b0, 1'b1, 19'd64, 2'b00, 16'h0000);
        @(negedge clk);
        check("oor0 set", {31'h0, oor0}, 32'h1);
        check("oor2 set", {31'h0, oor2}, 32'h1);
        check("oor wr_cnt unchanged", {16'h0, cnt0}, 32'd6);
        check("oor read zero", {16'h0, dq0}, 32'h0000);
        next_cycle();
        drive(1'b0, 1'b1, 19'd0, 2'b00, 16'h0000);
        @(negedge clk);
        check("oor alias addr0 intact", {16'h0, dq0}, 32'h0A0A);
        check("oor lat1 read zero", {16'h0, dq1}, 32'h0000);
        next_cycle();
        go_idle();
        next_cycle();
        next_cycle();

        // Reset with a latency-2 read in flight and a write presented.
        drive(1'b0, 1'b1, 19'd3, 2'b00, 16'h0000);
        next_cycle();
        rst = 1'b0;
        drive(1'b1, 1'b0, 19'd1, 2'b00, 16'hDEAD);
        next_cycle();
        rst = 1'b1;
        go_idle();
        @(negedge clk);
        check("rst dq2 dropped", {16'h0, dq2}, {16'h0, Z_READ});
        check("rst dq1 Z", {16'h0, dq1}, {16'h0, Z_READ});
        check("rst oor0", {31'h0, oor0}, 32'h0);
        check("rst oor2", {31'h0, oor2}, 32'h0);
        check("rst bc1", {31'h0, bc1}, 32'h0);
        check("rst cnt0", {16'h0, cnt0}, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 19'd1, 2'b00, 16'h0000);
        @(negedge clk);
        check("rst write ignored", {16'h0, dq0}, 32'h1111);
        next_cycle();
        drive(1'b0, 1'b1, 19'd7, 2'b00, 16'h0000);
        @(negedge clk);
        check("rst old word intact", {16'h0, dq0}, 32'h12FF);
        check("rst cnt0 still 0", {16'h0, cnt0}, 32'h0);
        next_cycle();
        go_idle();
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
